// File: rtl/park_pkg.sv
// Shared definitions for the parking-sensor front end: frame geometry,
// SPI master state encoding and default thresholds.
package park_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 11;
    localparam int DATA_LSB   = 4;

    localparam logic [7:0] THRESH_ON_DEF  = 8'd64;
    localparam logic [7:0] THRESH_OFF_DEF = 8'd96;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // Saturating increment for the 4-bit confirmation counters.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/spi_frame_master.sv
// Single-frame SPI read master: on start, clocks one 16-bit frame in
// MSB first and presents the 8 data bits with a one-cycle valid pulse.
module spi_frame_master
    import park_pkg::*;
#(
    parameter int SCLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       miso,
    output logic       ss,
    output logic       sclk,
    output logic [7:0] data,
    output logic       valid
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    spi_state_t                state_reg, state_next;
    logic [DIV_W-1:0]          div_reg;
    logic                      phase_reg;
    logic [3:0]                bit_reg;
    logic [FRAME_BITS-1:0]     shreg_reg;
    logic [7:0]                data_reg;
    logic                      valid_reg;
    logic                      div_done;
    logic                      last_half;
    logic                      unused_bits;

    assign div_done  = (div_reg == DIV_LAST);
    assign last_half = div_done && phase_reg && (bit_reg == 4'd15);

    // Only bits [11:4] of the frame carry ADC data.
    assign unused_bits = ^{shreg_reg[FRAME_BITS-1:DATA_MSB+1], shreg_reg[DATA_LSB-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start)     state_next = ST_SETUP;
            ST_SETUP: if (div_done)  state_next = ST_SHIFT;
            ST_SHIFT: if (last_half) state_next = ST_HOLD;
            ST_HOLD:  if (div_done)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // SS/SCLK decode straight from state so an async reset idles the bus at once.
    always_comb begin
        ss   = 1'b1;
        sclk = 1'b1;
        unique case (state_reg)
            ST_SETUP: ss = 1'b0;
            ST_SHIFT: begin
                ss   = 1'b0;
                sclk = phase_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg   <= '0;
            phase_reg <= 1'b0;
            bit_reg   <= 4'd0;
            shreg_reg <= '0;
            data_reg  <= 8'd0;
            valid_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE || div_done) begin
                div_reg <= '0;
            end else begin
                div_reg <= div_reg + 1'b1;
            end

            if (state_reg != ST_SHIFT) begin
                phase_reg <= 1'b0;
                bit_reg   <= 4'd0;
            end else if (div_done) begin
                phase_reg <= ~phase_reg;
                if (phase_reg) begin
                    bit_reg <= bit_reg + 4'd1;
                end
            end

            // Capture on the edge where SCLK rises (low half ending).
            if (state_reg == ST_SHIFT && div_done && !phase_reg) begin
                shreg_reg <= {shreg_reg[FRAME_BITS-2:0], miso};
            end

            valid_reg <= 1'b0;
            if (state_reg == ST_SHIFT && last_half) begin
                data_reg  <= shreg_reg[DATA_MSB:DATA_LSB];
                valid_reg <= 1'b1;
            end
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/spi_park_detector.sv
// Periodic ADC poll plus hysteresis/confirmation filter producing the
// debounced parked level.
module spi_park_detector
    import park_pkg::*;
#(
    parameter int         SCLK_DIV      = 50,
    parameter int         SAMPLE_PERIOD = 1_000_000,
    parameter logic [7:0] THRESH_ON     = THRESH_ON_DEF,
    parameter logic [7:0] THRESH_OFF    = THRESH_OFF_DEF,
    parameter int         CONFIRM       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MISO,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       parked
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]    CONFIRM_C   = 4'(CONFIRM);

    logic [TW-1:0] timer_reg;
    logic          tick;
    logic [7:0]    frame_data;
    logic          frame_valid;
    logic [3:0]    on_cnt_reg;
    logic [3:0]    off_cnt_reg;
    logic          parked_reg;
    logic [3:0]    on_cnt_next;
    logic [3:0]    off_cnt_next;

    assign tick = (timer_reg == PERIOD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
        end else if (tick) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    spi_frame_master #(
        .SCLK_DIV (SCLK_DIV)
    ) u_master (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tick),
        .miso  (MISO),
        .ss    (SS),
        .sclk  (SCLK),
        .data  (frame_data),
        .valid (frame_valid)
    );

    assign on_cnt_next  = sat_inc4(on_cnt_reg);
    assign off_cnt_next = sat_inc4(off_cnt_reg);

    // Only the counter facing the opposite state runs; the other stays at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_cnt_reg  <= 4'd0;
            off_cnt_reg <= 4'd0;
            parked_reg  <= 1'b0;
        end else if (frame_valid) begin
            if (!parked_reg) begin
                off_cnt_reg <= 4'd0;
                if (frame_data <= THRESH_ON) begin
                    if (on_cnt_next >= CONFIRM_C) begin
                        parked_reg <= 1'b1;
                        on_cnt_reg <= 4'd0;
                    end else begin
                        on_cnt_reg <= on_cnt_next;
                    end
                end else begin
                    on_cnt_reg <= 4'd0;
                end
            end else begin
                on_cnt_reg <= 4'd0;
                if (frame_data >= THRESH_OFF) begin
                    if (off_cnt_next >= CONFIRM_C) begin
                        parked_reg  <= 1'b0;
                        off_cnt_reg <= 4'd0;
                    end else begin
                        off_cnt_reg <= off_cnt_next;
                    end
                end else begin
                    off_cnt_reg <= 4'd0;
                end
            end
        end
    end

    assign MOSI         = 1'b0;
    assign sample       = frame_data;
    assign sample_valid = frame_valid;
    assign parked       = parked_reg;

endmodule

// File: tb/tb_spi_park_detector.sv
// Self-checking bench: ADC sensor model feeds frames, a scoreboard queue
// holds expected samples, and the filter response is checked per frame.
module tb_spi_park_detector;

    localparam int DIV  = 2;
    localparam int PER  = 100;
    localparam int CONF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       MISO = 1'b0;
    logic       SS, SCLK, MOSI;
    logic [7:0] sample;
    logic       sample_valid;
    logic       parked;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;

    logic [7:0]  data_q[$];
    logic [7:0]  exp_q[$];
    bit          miso_const = 1'b0;
    logic [15:0] cur_word = 16'h0;
    int          bit_idx = -1;

    always #5 clk = ~clk;

    spi_park_detector #(
        .SCLK_DIV      (DIV),
        .SAMPLE_PERIOD (PER),
        .THRESH_ON     (8'd64),
        .THRESH_OFF    (8'd96),
        .CONFIRM       (CONF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MISO         (MISO),
        .SS           (SS),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .sample       (sample),
        .sample_valid (sample_valid),
        .parked       (parked)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sensor: loads a frame word at SS fall, shifts a bit out on each SCLK fall.
    initial forever begin
        @(negedge SS);
        cur_word = (data_q.size() > 0) ? {4'h0, data_q.pop_front(), 4'h0} : 16'h0000;
        if (miso_const) cur_word = 16'hFFFF;
        exp_q.push_back(cur_word[11:4]);
        bit_idx = 15;
        MISO = miso_const;
    end

    initial forever begin
        @(negedge SCLK);
        if (SS === 1'b0 && bit_idx >= 0) begin
            MISO = cur_word[bit_idx];
            bit_idx--;
        end
    end

    // Scoreboard consumer: one line per captured frame.
    initial forever begin
        @(negedge clk);
        if (rst_n && sample_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check_val("sb_nonempty", 16'(exp_q.size()), 16'd1);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("frame %0d: sample=%02h expected=%02h parked=%0b", valid_cnt, sample, e, parked);
                check_val("sample", {8'h0, sample}, {8'h0, e});
            end
            check_val("ss_at_valid", {15'h0, SS}, 16'd1);
            check_val("mosi", {15'h0, MOSI}, 16'd0);
        end
    end

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_val({tag, "_seen"}, {15'h0, ok}, 16'd1);
    endtask

    task automatic frame_step(input logic [7:0] d, input logic park_now, input logic park_next,
                              input string tag);
        data_q.push_back(d);
        wait_valid(tag);
        check_val({tag, "_park_v"}, {15'h0, parked}, {15'h0, park_now});
        @(negedge clk);
        check_val({tag, "_park_n"}, {15'h0, parked}, {15'h0, park_next});
    endtask

    initial begin
        int n, rises, vc;
        logic prev;

        data_q.push_back(8'h30);
        repeat (5) @(negedge clk);
        check_val("rst_ss", {15'h0, SS}, 16'd1);
        check_val("rst_sclk", {15'h0, SCLK}, 16'd1);
        check_val("rst_parked", {15'h0, parked}, 16'd0);
        check_val("rst_valid", {15'h0, sample_valid}, 16'd0);
        check_val("rst_sample", {8'h0, sample}, 16'd0);
        check_val("rst_mosi", {15'h0, MOSI}, 16'd0);

        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (SS !== 1'b0 && n < 1000);
        check_val("first_ss_fall", 16'(n), 16'd100);

        n = 0;
        rises = 0;
        prev = SCLK;
        do begin
            @(negedge clk);
            n++;
            if (prev === 1'b0 && SCLK === 1'b1) rises++;
            prev = SCLK;
        end while (SS !== 1'b1 && n < 1000);
        check_val("ss_low_len", 16'(n), 16'd66);
        check_val("sclk_rises", 16'(rises), 16'd16);
        check_val("valid_first_ss_high", {15'h0, sample_valid}, 16'd1);

        // 0x30 counted once as covered; in-band sample clears it.
        frame_step(8'h50, 1'b0, 1'b0, "inband_a");
        for (int i = 0; i < 3; i++) frame_step(8'h40, 1'b0, 1'b0, "on3");
        frame_step(8'h50, 1'b0, 1'b0, "inband_b");
        for (int i = 0; i < 3; i++) frame_step(8'h40, 1'b0, 1'b0, "on4_pre");
        frame_step(8'h40, 1'b0, 1'b1, "on4_last");

        for (int i = 0; i < 3; i++) frame_step(8'h70, 1'b1, 1'b1, "off3");
        frame_step(8'h50, 1'b1, 1'b1, "inband_c");
        for (int i = 0; i < 3; i++) frame_step(8'h70, 1'b1, 1'b1, "off4_pre");
        frame_step(8'h70, 1'b1, 1'b0, "off4_last");

        // Reset in the low half of the 8th SCLK period.
        data_q.push_back(8'h40);
        n = 0;
        while (SS !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_ss_fall", {15'h0, SS}, 16'd0);
        rises = 0;
        prev = SCLK;
        while (rises < 7 && n < 600) begin
            @(negedge clk);
            n++;
            if (prev === 1'b0 && SCLK === 1'b1) rises++;
            prev = SCLK;
        end
        while (SCLK !== 1'b0 && n < 700) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_sclk_low", {15'h0, SCLK}, 16'd0);
        vc = valid_cnt;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ss", {15'h0, SS}, 16'd1);
        check_val("mid_rst_sclk", {15'h0, SCLK}, 16'd1);
        exp_q.delete();
        data_q.delete();
        miso_const = 1'b1;
        MISO = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (SS !== 1'b0 && n < 1000);
        check_val("post_rst_ss_fall", 16'(n), 16'd100);
        check_val("post_rst_no_valid", 16'(valid_cnt), 16'(vc));
        check_val("post_rst_sample", {8'h0, sample}, 16'd0);

        // Constant MISO=1: saturated reading is "clear", never parks.
        for (int i = 0; i < 5; i++) begin
            wait_valid("ff");
            @(negedge clk);
            check_val("ff_parked", {15'h0, parked}, 16'd0);
        end
        check_val("ff_sample", {8'h0, sample}, 16'h00FF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/spi_park_detector.md
Name: spi_park_detector

Overview:
- Upstream stage of the meter. Polls an 8-bit SPI light/proximity ADC (ADC081S021-style frame) at a fixed rate and produces the debounced `parked` level.
- `parked` feeds the second counter, the cost/time digit mux and the display controller.
- Applies threshold hysteresis plus N-consecutive-sample confirmation, so the meter never toggles on sensor noise.

Parameters:
- SCLK_DIV, 50: clk cycles per SCLK half-period (1 MHz at 100 MHz clk). Must be ≥2.
- SAMPLE_PERIOD, 1_000_000: clk cycles between frame starts (10 ms). Must exceed 36*SCLK_DIV.
- THRESH_ON, 8'd64: sample ≤ this counts as "covered".
- THRESH_OFF, 8'd96: sample ≥ this counts as "clear". Must satisfy THRESH_ON < THRESH_OFF.
- CONFIRM, 4: consecutive qualifying samples required to change `parked` (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- MISO  in  1  serial data from sensor
- SS  out  1  chip select, active low
- SCLK  out  1  serial clock, idles high
- MOSI  out  1  constant 0
- sample  out  8  last captured ADC value
- sample_valid  out  1  one-cycle pulse when `sample` updates
- parked  out  1  debounced occupancy level

Behaviour:
- Reset (async assert, sync release): SS=1, SCLK=1, MOSI=0, sample=0, sample_valid=0, parked=0. Period timer, bit counter and confirm counters are cleared; FSM goes to IDLE.
- Period timer counts 0..SAMPLE_PERIOD-1 and wraps, emitting `tick` on the wrap. The first tick occurs SAMPLE_PERIOD cycles after reset release.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
  - IDLE: on tick, drive SS=0 and go to SETUP. A tick arriving in any other state is dropped, not queued.
  - SETUP: hold SS=0, SCLK=1 for SCLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 SCLK periods. Each period is SCLK low for SCLK_DIV cycles, then SCLK high for SCLK_DIV cycles.
    - MISO is captured into a 16-bit shift register, MSB first, on the clk edge where SCLK goes 0→1.
    - After the 16th high half, go to HOLD.
  - HOLD: SS=1, SCLK=1 for SCLK_DIV cycles, then return to IDLE.
    - On the first HOLD cycle, sample <= shreg[11:4] and sample_valid=1 for exactly one cycle.
- Frame length from SS fall to SS rise = 33*SCLK_DIV cycles.
- Filter, evaluated on the sample_valid cycle using the newly captured sample:
  - parked=0: if sample ≤ THRESH_ON, on_cnt++; otherwise on_cnt=0. When on_cnt reaches CONFIRM, parked becomes 1 on the next cycle and on_cnt clears.
  - parked=1: if sample ≥ THRESH_OFF, off_cnt++; otherwise off_cnt=0. When off_cnt reaches CONFIRM, parked becomes 0 and off_cnt clears.
  - A sample strictly between the thresholds resets the active counter and holds `parked`.
  - Boundary values are inclusive: sample == THRESH_ON qualifies as covered, sample == THRESH_OFF qualifies as clear.
- Counters saturate and never wrap. Only one counter is active at a time; the inactive counter is held at 0.
- Reset mid-frame: SS/SCLK return to idle immediately (asynchronously), and the partial frame is discarded with no sample_valid.
- MOSI is tied 0. No MISO synchronizer is required: MISO is sampled ≥SCLK_DIV cycles after the sensor's SCLK-falling update. A 2-flop synchronizer is permitted if it is matched by a capture delay.

Decomposition:
- Shared package (park_pkg): FRAME_BITS=16, DATA_MSB=11, DATA_LSB=4, FSM state encoding, default thresholds.
- One sub-module: spi_frame_master. It holds the FSM, SCLK divider, shift register and sample/sample_valid, with start=tick in and data/valid out.
- The filter and period timer stay in spi_park_detector.

Test Plan (sim with SCLK_DIV=2, SAMPLE_PERIOD=100, CONFIRM=4):
- Hold rst_n=0 → SS=1, SCLK=1, parked=0, sample_valid=0. Release → first SS fall at cycle 100 after release; SS low for 66 cycles; 16 SCLK rising edges.
- Sensor model drives frame 16'h0300 (data 8'h30) → sample=8'h30. sample_valid is high one cycle, on the first cycle SS is high.
- Four consecutive frames with data 8'h40 (== THRESH_ON) → parked rises one cycle after the 4th sample_valid. Three frames of 8'h40 followed by 8'h50 → parked stays 0.
- With parked=1: alternate 8'h70 (≥96) ×3, then 8'h50 (in-band), then 8'h70 ×4 → parked stays 1 until the 4th of the final run, then falls.
- Assert rst_n=0 during the 8th SCLK of a frame → SS and SCLK go high combinationally-async, no sample_valid. The next frame starts 100 cycles after release, and sample retains 0.
- Constant MISO=1 → sample=8'hFF and parked never asserts. MOSI stays 0 throughout every test.
